// File: rtl/demux1_to_4_sar_if.sv
// Bundles the stream signals of the 1-to-4 packet demultiplexer.
//   in_valid/in_ready/in_data/in_last/sel : input stream and lane select
//   out_valid/out_ready/out_data/out_last : four output lanes, lane i at bit i / [i*W +: W]
//   busy/active_lane                      : packet-in-progress status
// master: the side that sources the input stream and sinks the lanes.
// slave : the demultiplexer itself.
interface demux1_to_4_sar_if #(
  parameter int unsigned W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic [1:0]     sel;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_last;
  logic           busy;
  logic [1:0]     active_lane;

  modport master (
    output in_valid, in_data, in_last, sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, active_lane
  );

  modport slave (
    input  in_valid, in_data, in_last, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, active_lane
  );
endinterface

// File: rtl/demux1_to_4_sar.sv
// Registered 1-to-4 packet demultiplexer.
// The lane is taken from sel on the first beat of a packet and locked until the beat
// marked last. Every lane has its own 2-entry in-order buffer, so a stalled lane only
// blocks packets aimed at it.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : demux1_to_4_sar_if.slave (input stream, four output lanes, busy/active_lane)
module demux1_to_4_sar #(
  parameter int unsigned W = 8
) (
  input logic              clk,
  input logic              rst,
  demux1_to_4_sar_if.slave bus
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StRoute = 1'b1;

  typedef logic [W:0] entry_t;  // {last, data}

  logic [0:0]            state_q, state_d;
  logic [1:0]            active_q, active_d;
  entry_t [3:0][1:0]     ent_q, ent_d;   // [lane][0] is the head entry
  logic   [3:0][1:0]     cnt_q, cnt_d;
  logic [1:0]            lane;
  logic                  accept;
  logic [3:0]            push, pop;
  entry_t                new_entry;

  // Lane select: sel only matters on the first beat of a packet.
  assign lane      = (state_q == StRoute) ? active_q : bus.sel;
  // Based on the stored count only, so out_ready never reaches in_ready combinationally.
  assign bus.in_ready = !rst && (cnt_q[lane] != 2'd2);
  assign accept    = bus.in_valid && bus.in_ready;
  assign new_entry = {bus.in_last, bus.in_data};

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 4; i++) begin
      push[i] = accept && (lane == 2'(i));
      pop[i]  = (cnt_q[i] != 2'd0) && bus.out_ready[i];
    end
  end

  // Packet FSM
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    if (accept) begin
      if (state_q == StIdle) begin
        active_d = bus.sel;
        state_d  = bus.in_last ? StIdle : StRoute;
      end else if (bus.in_last) begin
        state_d = StIdle;
      end
    end
  end

  // Lane buffers: shift-style 2-entry FIFOs with the head always in slot 0.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (push[i] && pop[i]) begin
        // Only reachable with count 1: the head leaves and the new beat replaces it.
        ent_d[i][0] = new_entry;
      end else if (push[i]) begin
        if (cnt_q[i] == 2'd0) begin
          ent_d[i][0] = new_entry;
          cnt_d[i]    = 2'd1;
        end else begin
          ent_d[i][1] = new_entry;
          cnt_d[i]    = 2'd2;
        end
      end else if (pop[i]) begin
        ent_d[i][0] = ent_q[i][1];
        cnt_d[i]    = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      active_q <= 2'd0;
      ent_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ent_q    <= ent_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.out_last  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_valid[i] = (cnt_q[i] != 2'd0);
      // Empty lanes present zero rather than stale slot contents.
      if (cnt_q[i] != 2'd0) begin
        bus.out_data[i*W +: W] = ent_q[i][0][W-1:0];
        bus.out_last[i]        = ent_q[i][0][W];
      end
    end
  end

  assign bus.busy        = (state_q == StRoute);
  assign bus.active_lane = active_q;

endmodule

// File: tb/tb_demux1_to_4_sar.sv
// Bench for demux1_to_4_sar: a table of single-cycle vectors, hand-written multi-cycle
// sequences, then random traffic, all shadowed by a queue-based reference model.
module tb_demux1_to_4_sar;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux1_to_4_sar_if #(.W(W)) bus ();
  demux1_to_4_sar #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue of {last, data} per lane plus packet-lock state.
  logic [8:0] mq [4][$];
  bit         m_pkt;
  logic [1:0] m_act;

  typedef struct {
    logic       r;
    logic       vld;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [3:0] ordy;
    logic       x_rdy;    // in_ready before the edge
    logic [3:0] x_ov;     // out_valid after the edge
    logic [1:0] x_lane;   // lane whose head is checked after the edge
    logic [7:0] x_data;
    logic       x_last;
    logic       x_busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic l, input logic [3:0] ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.sel       = s;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
  endtask

  function automatic logic [1:0] m_lane();
    return m_pkt ? m_act : bus.sel;
  endfunction

  function automatic logic m_ready();
    return !rst && (mq[m_lane()].size() < 2);
  endfunction

  // Compare the DUT with the model, advance the model and the clock by one cycle.
  task automatic cycle();
    logic [3:0]  xov, xol;
    logic [31:0] xod;
    logic        acc;
    logic [1:0]  ln;
    xov = '0;
    xol = '0;
    xod = '0;
    for (int i = 0; i < 4; i++) begin
      if (mq[i].size() > 0) begin
        xov[i]        = 1'b1;
        xod[i*8 +: 8] = mq[i][0][7:0];
        xol[i]        = mq[i][0][8];
      end
    end
    chk("model in_ready", bus.in_ready, m_ready());
    chk("model out_valid", bus.out_valid, xov);
    chk("model out_data", bus.out_data, xod);
    chk("model out_last", bus.out_last, xol);
    chk("model busy", bus.busy, m_pkt);
    chk("model active_lane", bus.active_lane, m_act);
    acc = bus.in_valid && m_ready();
    ln  = m_lane();
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_pkt = 1'b0;
      m_act = 2'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mq[i].size() > 0 && bus.out_ready[i]) void'(mq[i].pop_front());
      if (acc) begin
        mq[ln].push_back({bus.in_last, bus.in_data});
        if (!m_pkt) begin
          m_act = bus.sel;
          m_pkt = !bus.in_last;
        end else if (bus.in_last) begin
          m_pkt = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hold;
    logic v, l, r;
    logic [1:0] s;
    logic [7:0] d;

    //           r  vld sel data   last ordy   rdy ov      ln  data   last busy
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 8'h11, 1'b0, 4'hF, 1'b1, 4'b0010, 2'd1, 8'h11, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'd3, 8'h22, 1'b0, 4'hF, 1'b1, 4'b0010, 2'd1, 8'h22, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 8'h33, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 8'h33, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd1, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 8'h5A, 1'b0, 4'h0, 1'b1, 4'b0001, 2'd0, 8'h5A, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 8'h5B, 1'b1, 4'h0, 1'b1, 4'b0001, 2'd0, 8'h5A, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 8'h7E, 1'b1, 4'h0, 1'b1, 4'b1001, 2'd3, 8'h7E, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 4'b1001, 2'd0, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h1, 1'b0, 4'b1001, 2'd0, 8'h5B, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd3, 8'h00, 1'b0, 1'b0};

    // Initial reset without comparison: DUT state is unknown before the first edge.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    m_pkt = 1'b0;
    m_act = 2'd0;

    // Table: single beat, lane lock, lane independence with a full stalled lane.
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].r, tbl[k].vld, tbl[k].sel, tbl[k].data, tbl[k].last, tbl[k].ordy);
      chk($sformatf("vec%0d in_ready", k), bus.in_ready, tbl[k].x_rdy);
      cycle();
      chk($sformatf("vec%0d out_valid", k), bus.out_valid, tbl[k].x_ov);
      chk($sformatf("vec%0d lane data", k), bus.out_data[tbl[k].x_lane*8 +: 8], tbl[k].x_data);
      chk($sformatf("vec%0d lane last", k), bus.out_last[tbl[k].x_lane], tbl[k].x_last);
      chk($sformatf("vec%0d busy", k), bus.busy, tbl[k].x_busy);
    end

    // Backpressure on lane 0.
    drive(1'b0, 1'b1, 2'd0, 8'h01, 1'b0, 4'h0);
    chk("bp beat1 ready", bus.in_ready, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 2'd0, 8'h02, 1'b0, 4'h0);
    chk("bp beat2 ready", bus.in_ready, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 2'd0, 8'h03, 1'b1, 4'h0);
    chk("bp full ready", bus.in_ready, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 2'd0, 8'h03, 1'b1, 4'h1);
    chk("bp popping still not ready", bus.in_ready, 1'b0);
    chk("bp head 01", bus.out_data[7:0], 8'h01);
    cycle();
    chk("bp ready after pop", bus.in_ready, 1'b1);
    chk("bp head 02", bus.out_data[7:0], 8'h02);
    cycle();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h1);
    chk("bp head 03", bus.out_data[7:0], 8'h03);
    chk("bp last on 03", bus.out_last[0], 1'b1);
    cycle();
    chk("bp drained", bus.out_valid, 4'b0000);

    // Reset in the middle of a packet to lane 1.
    drive(1'b0, 1'b1, 2'd1, 8'h44, 1'b0, 4'h0);
    cycle();
    chk("rst pre busy", bus.busy, 1'b1);
    drive(1'b1, 1'b1, 2'd1, 8'h45, 1'b0, 4'h0);
    chk("rst in_ready low", bus.in_ready, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 2'd0, 8'h99, 1'b1, 4'h0);
    chk("rst out_valid", bus.out_valid, 4'b0000);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst active_lane", bus.active_lane, 2'd0);
    chk("rst next ready", bus.in_ready, 1'b1);
    cycle();
    chk("rst next lands lane0", bus.out_valid, 4'b0001);
    chk("rst next data", bus.out_data[7:0], 8'h99);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    cycle();

    // Streaming 8 beats into lane 2 with its consumer always ready.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 2'd2, 8'(k), (k == 7), 4'h4);
      chk($sformatf("stream%0d ready", k), bus.in_ready, 1'b1);
      cycle();
      chk($sformatf("stream%0d out_valid", k), bus.out_valid, 4'b0100);
      chk($sformatf("stream%0d data", k), bus.out_data[23:16], 8'(k));
      chk($sformatf("stream%0d busy", k), bus.busy, (k != 7));
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'h4);
    cycle();
    chk("stream drained", bus.out_valid, 4'b0000);

    // Random traffic; the source holds an unaccepted beat stable.
    hold = 1'b0;
    v = 1'b0; l = 1'b0; s = 2'd0; d = 8'h00;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 80) == 0);
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
        l = ($urandom_range(0, 2) == 0);
      end
      drive(r, v, s, d, l, 4'($urandom));
      hold = v && !r && !m_ready();
      cycle();
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    cycle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/demux1_to_4_sar.md
Name: demux1_to_4_sar

Overview:
- Registered 1-to-4 packet demultiplexer: the distribution-side counterpart of the team's 4-to-1 mux.
- Routes a valid/ready input stream to one of four output lanes.
- The lane is chosen by sel on the first beat of a packet and held until the beat marked last.
- Each lane has a 2-entry buffer, so a stalled lane does not block traffic to the other lanes.

Parameters:
W, 8, data width in bits per beat.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input beat present.
in_ready  output  1  block accepts the beat this cycle.
in_data  input  W  input beat payload.
in_last  input  1  final beat of the packet.
sel  input  2  destination lane (0..3); sampled only on the first beat of a packet.
out_valid  output  4  bit i: lane i head entry valid.
out_ready  input  4  bit i: lane i consumer accepts head.
out_data  output  4*W  lane i payload at bits [i*W +: W].
out_last  output  4  bit i: lane i head is last beat of its packet.
busy  output  1  high while a multi-beat packet is in progress (ROUTE state).
active_lane  output  2  lane locked by the current packet.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Empties all four buffers and forces state to IDLE.
  - out_valid=0, out_data=0, out_last=0, busy=0, active_lane=0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-packet discards all buffered and in-flight beats; no partial-packet recovery.
- Handshake:
  - A beat is accepted when in_valid & in_ready at a clk edge.
  - The source holds in_valid, in_data, in_last and sel stable until the beat is accepted.
  - A lane's output is transferred when out_valid[i] & out_ready[i].
- Lane select:
  - In IDLE, lane = sel (combinational).
  - In ROUTE, lane = active_lane; sel is ignored.
- in_ready = !rst & (count[lane] != 2).
  - There is no combinational path from out_ready to in_ready, so a full lane deasserts in_ready even if it is popping that cycle.
- FSM with two states, IDLE and ROUTE:
  - IDLE, accept with in_last=0 -> ROUTE; active_lane <= sel.
  - IDLE, accept with in_last=1 -> stay IDLE (single-beat packet); active_lane <= sel.
  - ROUTE, accept with in_last=1 -> IDLE.
  - ROUTE otherwise -> hold.
  - busy = (state == ROUTE).
- Lane buffers:
  - Per-lane 2-entry FIFO of {last, data}, count 0..2, strict in-order.
  - out_valid[i] = (count[i] != 0); out_data / out_last present the head entry.
  - out_data for an empty lane = 0.
- Latency: an accepted beat appears on its lane at the next clk edge (1 cycle).
- Simultaneous push and pop on the same lane:
  - count=1: stays 1 and the head advances.
  - count=2: push is impossible (in_ready=0); pop gives count=1.
  - count=0: push only.
- Throughput: 1 beat/cycle per packet when the target lane's out_ready is held high.
- Lanes are independent:
  - Pops on other lanes occur in the same cycle as a push on the active lane.
  - A full, stalled lane blocks only packets destined to it.
- Unaccepted in_valid beats have no effect on state. out_ready on empty lanes is ignored.

Test Plan:
1. Single-beat packet:
   - Stimulus: after reset, sel=2, in_data=0xA5, in_last=1, out_ready=4'hF.
   - Required response: next cycle out_valid=4'b0100, lane 2 data=0xA5, out_last[2]=1, busy stays 0.
2. Lane lock:
   - Stimulus: 3-beat packet 0x11, 0x22, 0x33 with sel=1 on beat 1; sel changed to 3 for beats 2-3.
   - Required response: all three beats appear on lane 1 in order, out_last[1]=1 only on 0x33.
   - busy=1 from the cycle after beat 1 until the cycle after beat 3; active_lane=1.
3. Backpressure:
   - Stimulus: out_ready[0]=0; send 0x01, 0x02, 0x03 to lane 0 as one packet.
   - Required response: two beats accepted, then in_ready=0.
   - After out_ready[0]=1, lane 0 drains 0x01, 0x02, 0x03 in order; 0x03 is accepted in the cycle after the first pop.
4. Lane independence:
   - Stimulus: lane 0 full and stalled (out_ready[0]=0); new single-beat packet sel=3, data 0x7E.
   - Required response: accepted immediately; lane 3 shows 0x7E one cycle later; lane 0 contents unchanged.
5. Reset mid-packet:
   - Stimulus: after beat 1 of a packet to lane 1, assert rst for one cycle.
   - Required response: out_valid=0, busy=0, active_lane=0.
   - Next beat with sel=0, in_last=1 lands on lane 0.
6. Streaming:
   - Stimulus: 8-beat packet 0x00..0x07 to lane 2 with out_ready[2]=1 and in_valid continuous.
   - Required response: in_ready stays 1; beats accepted in 8 consecutive cycles; outputs appear 1 cycle later with no gaps; lane 2 count never exceeds 1.
